fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ROM_WIDTH, default 21, the instruction word width.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, the PC value after reset.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ADDR  output  16  program memory address, driven combinationally from PC.
REQ-006 SHALL have port data  input  ROM_WIDTH  asynchronous program memory read data for ADDR.
REQ-007 SHALL have port instr  output  ROM_WIDTH  held instruction word to the execute stage.
REQ-008 SHALL have port instr_pc  output  16  address the held instruction was fetched from.
REQ-009 SHALL have port instr_valid  output  1  held instruction is valid.
REQ-010 SHALL have port instr_ready  input  1  execute stage accepts; a transfer occurs when instr_valid and instr_ready are both high.
REQ-011 SHALL have port redirect_valid  input  1  jump request, one-cycle pulse.
REQ-012 SHALL have port redirect_addr  input  16  jump target.
REQ-013 SHALL have port halt_req  input  1  stop fetching.
REQ-014 SHALL have port resume_req  input  1  restart fetching.
REQ-015 SHALL have port halted  output  1  high while in state HALTED.

Function
REQ-016 SHALL implement states RUN and HALTED; HALTED drives halted=1.
REQ-017 SHALL define load as: state RUN, no redirect_valid, and either instr_valid=0 or a transfer in the same cycle.
REQ-018 On load, SHALL register instr<=data, instr_pc<=PC, instr_valid<=1, PC<=PC+1, all on the same edge.
REQ-019 On a transfer without load, SHALL clear instr_valid on the next edge.
REQ-020 SHALL hold instr and instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-021 SHALL increment PC modulo 2^16, so 16'hFFFF is followed by 16'h0000 with no flag.
REQ-022 On redirect_valid, SHALL set PC<=redirect_addr, clear instr_valid, and discard the held word regardless of instr_ready.
REQ-023 After a redirect, the target instruction SHALL appear with instr_valid=1 on the second rising edge after the redirect cycle, provided the block is in RUN.
REQ-024 redirect_valid SHALL be honoured in both states; the state is unchanged by a redirect.
REQ-025 On halt_req in RUN, SHALL go to HALTED on the next edge; a load in that same cycle still completes.
REQ-026 In HALTED, SHALL perform no loads, keep PC fixed, and keep any held word offered until it is transferred.
REQ-027 On resume_req in HALTED, SHALL go to RUN on the next edge.
REQ-028 When halt_req and resume_req are both high, halt_req SHALL win.
REQ-029 resume_req in RUN and halt_req in HALTED SHALL have no effect.

Reset
REQ-030 While RST=1 at an edge, SHALL set PC<=RESET_PC, instr_valid<=0, instr<=0, instr_pc<=0, state<=RUN, halted<=0.
REQ-031 RST SHALL override redirect, halt and resume, and abort any held word.
REQ-032 The first load SHALL occur on the first edge with RST=0.

Configuration
REQ-033 With macro FETCH_BKPT_EN defined, SHALL add ports bkpt_en (input, 1) and bkpt_addr (input, 16).
REQ-034 With FETCH_BKPT_EN defined, a load whose PC equals bkpt_addr while bkpt_en=1 SHALL complete normally and move the block to HALTED on the same edge.
REQ-035 Without FETCH_BKPT_EN, the breakpoint ports and logic SHALL be absent, and HALTED SHALL be entered only through halt_req.

Structure
REQ-036 SHALL place the state encoding (RUN, HALTED), the default ROM_WIDTH and the default RESET_PC in the shared processor package.
REQ-037 SHALL contain one sub-module, fetch_ctrl, holding the state register and the halt, resume and breakpoint logic; PC and the output register stay in fetch_unit.

Verification
REQ-038 Reset then instr_ready=1 held high, with ROM word k = k: SHALL give instr_pc = 0, 1, 2, 3 on consecutive cycles with instr_valid=1 every cycle.
REQ-039 Back-pressure: with instr_ready=0 for 3 cycles while instr_pc=2, SHALL keep instr and instr_pc unchanged and PC=3; after release, SHALL present instr_pc=3 on the next cycle.
REQ-040 Redirect: redirect_valid with redirect_addr=16'h000C in the cycle instr_pc=5 SHALL give instr_valid=0 for one cycle, then instr_pc=16'h000C.
REQ-041 Wrap: redirect to 16'hFFFF SHALL give instr_pc=16'hFFFF followed by 16'h0000.
REQ-042 Halt and resume: halt_req while instr_ready=0 SHALL set halted=1, keep the word offered, and make no new loads after it is transferred; resume_req SHALL restart loads; halt_req and resume_req together SHALL keep halted=1.
REQ-043 Breakpoint (FETCH_BKPT_EN defined): bkpt_addr=4 with bkpt_en=1 SHALL deliver instr_pc=4 and then set halted=1, with PC=5.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared processor package for the fetch stage: RUN/HALTED encoding, default
// instruction width and reset PC, and the PC increment helper.
package fetch_unit_pkg;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

   localparam int          ROM_WIDTH_DEFAULT = 21;
   localparam logic [15:0] RESET_PC_DEFAULT  = 16'h0000;

   // PC advance wraps silently at 16'hFFFF
   function automatic logic [15:0] pc_incr(input logic [15:0] pc);
      return pc + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// RUN/HALTED controller for fetch_unit. With FETCH_BKPT_EN defined, a load
// from bkpt_addr while bkpt_en is set also moves the block to HALTED.
module fetch_ctrl
   import fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        halt_req,
   input  logic        resume_req,
`ifdef FETCH_BKPT_EN
   input  logic        load,
   input  logic [15:0] pc,
   input  logic        bkpt_en,
   input  logic [15:0] bkpt_addr,
`endif
   output logic        run,
   output logic        halted
);

   fetch_state_e state_r;
   fetch_state_e state_next_s;
   logic         bkpt_hit_s;

`ifdef FETCH_BKPT_EN
   // Qualified by the load itself so the word at bkpt_addr is still delivered
   assign bkpt_hit_s = load && bkpt_en && (pc == bkpt_addr);
`else
   assign bkpt_hit_s = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= RUN;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; halt_req has priority over resume_req
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         RUN: begin
            if (halt_req || bkpt_hit_s) begin
               state_next_s = HALTED;
            end else begin
               state_next_s = RUN;
            end
         end
         HALTED: begin
            if (halt_req) begin
               state_next_s = HALTED;
            end else if (resume_req) begin
               state_next_s = RUN;
            end else begin
               state_next_s = HALTED;
            end
         end
         default: state_next_s = RUN;
      endcase
   end

   assign run    = (state_r == RUN);
   assign halted = (state_r == HALTED);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, program memory addressing and a one-entry
// valid/ready output register. Optional breakpoint via macro FETCH_BKPT_EN.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int          ROM_WIDTH = ROM_WIDTH_DEFAULT,
   parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT
) (
   input  logic                 CLK,
   input  logic                 RST,
   output logic [15:0]          ADDR,
   input  logic [ROM_WIDTH-1:0] data,
   output logic [ROM_WIDTH-1:0] instr,
   output logic [15:0]          instr_pc,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   input  logic                 redirect_valid,
   input  logic [15:0]          redirect_addr,
   input  logic                 halt_req,
   input  logic                 resume_req,
`ifdef FETCH_BKPT_EN
   input  logic                 bkpt_en,
   input  logic [15:0]          bkpt_addr,
`endif
   output logic                 halted
);

   logic [15:0]          pc_r;
   logic [ROM_WIDTH-1:0] instr_r;
   logic [15:0]          instr_pc_r;
   logic                 instr_valid_r;
   logic                 run_s;
   logic                 transfer_s;
   logic                 load_s;

   assign transfer_s = instr_valid_r && instr_ready;
   // Refill the output register when it is empty or being drained this cycle
   assign load_s     = run_s && !redirect_valid && (!instr_valid_r || transfer_s);

   fetch_ctrl u_ctrl (
      .clk        (CLK),
      .rst        (RST),
      .halt_req   (halt_req),
      .resume_req (resume_req),
`ifdef FETCH_BKPT_EN
      .load       (load_s),
      .pc         (pc_r),
      .bkpt_en    (bkpt_en),
      .bkpt_addr  (bkpt_addr),
`endif
      .run        (run_s),
      .halted     (halted)
   );

   // PC and output register; a redirect discards the held word even if accepted
   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_r          <= RESET_PC;
         instr_r       <= {ROM_WIDTH{1'b0}};
         instr_pc_r    <= 16'h0000;
         instr_valid_r <= 1'b0;
      end else if (redirect_valid) begin
         pc_r          <= redirect_addr;
         instr_valid_r <= 1'b0;
      end else if (load_s) begin
         instr_r       <= data;
         instr_pc_r    <= pc_r;
         instr_valid_r <= 1'b1;
         pc_r          <= pc_incr(pc_r);
      end else if (transfer_s) begin
         instr_valid_r <= 1'b0;
      end else begin
         instr_valid_r <= instr_valid_r;
      end
   end

   assign ADDR        = pc_r;
   assign instr       = instr_r;
   assign instr_pc    = instr_pc_r;
   assign instr_valid = instr_valid_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios followed by random
// traffic; a negedge monitor compares transfers against an expected PC stream.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int W = 21;

   logic          CLK = 1'b0;
   logic          RST;
   logic [15:0]   ADDR;
   logic [W-1:0]  data;
   logic [W-1:0]  instr;
   logic [15:0]   instr_pc;
   logic          instr_valid;
   logic          instr_ready;
   logic          redirect_valid;
   logic [15:0]   redirect_addr;
   logic          halt_req;
   logic          resume_req;
   logic          halted;
`ifdef FETCH_BKPT_EN
   logic          bkpt_en = 1'b0;
   logic [15:0]   bkpt_addr = 16'h0000;
`endif

   int            total = 0;
   int            bad = 0;
   int            xfers = 0;
   logic [15:0]   exp_q[$];
   logic          mon_en = 1'b0;
   logic          exp_halted, drained, prev_rst, prev_stall, prev_flush;
   logic [15:0]   prev_pc;
   logic [W-1:0]  prev_instr;
   logic          xfer, ld, hit, nh;

   fetch_unit dut (
      .CLK            (CLK),
      .RST            (RST),
      .ADDR           (ADDR),
      .data           (data),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .halt_req       (halt_req),
      .resume_req     (resume_req),
`ifdef FETCH_BKPT_EN
      .bkpt_en        (bkpt_en),
      .bkpt_addr      (bkpt_addr),
`endif
      .halted         (halted)
   );

   always #5 CLK = ~CLK;

   function automatic logic [W-1:0] rom_word(input logic [15:0] a);
      return {a[4:0] ^ 5'h0B, a};
   endfunction

   assign data = rom_word(ADDR);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Expected accepted-PC stream from a new start point: sequential, wrapping
   task automatic new_segment(input logic [15:0] t);
      exp_q.delete();
      for (int i = 0; i < 4096; i++) exp_q.push_back(t + 16'(i));
   endtask

   task automatic drive(input logic r, input logic rdy, input logic rv, input logic [15:0] ra,
                        input logic h, input logic rs);
      RST            = r;
      instr_ready    = rdy && !rv && !r;
      redirect_valid = rv;
      redirect_addr  = ra;
      halt_req       = h;
      resume_req     = rs;
      if (r) new_segment(16'h0000);
      else if (rv) new_segment(ra);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Monitor: invariants, halt model and scoreboard pops
   always @(negedge CLK) begin
      if (mon_en) begin
         check("halted", {31'd0, halted}, {31'd0, exp_halted});
         if (prev_rst) begin
            check("rst_valid", {31'd0, instr_valid}, 32'd0);
            check("rst_instr", {11'd0, instr}, 32'd0);
            check("rst_instr_pc", {16'd0, instr_pc}, 32'd0);
            check("rst_addr", {16'd0, ADDR}, 32'd0);
         end
         if (instr_valid) check("addr_after_word", {16'd0, ADDR}, {16'd0, instr_pc + 16'd1});
         if (prev_stall && !prev_flush) begin
            check("hold_valid", {31'd0, instr_valid}, 32'd1);
            check("hold_pc", {16'd0, instr_pc}, {16'd0, prev_pc});
            check("hold_instr", {11'd0, instr}, {11'd0, prev_instr});
         end
         if (exp_halted && drained) check("halted_no_load", {31'd0, instr_valid}, 32'd0);
         xfer = instr_valid && instr_ready && !RST;
         if (xfer) begin
            xfers++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_empty: actual pc=%0h required=none", instr_pc);
            end else begin
               check("sb_pc", {16'd0, instr_pc}, {16'd0, exp_q[0]});
               check("sb_instr", {11'd0, instr}, {11'd0, rom_word(exp_q[0])});
               void'(exp_q.pop_front());
            end
         end
         ld  = !exp_halted && !redirect_valid && (!instr_valid || xfer);
         hit = 1'b0;
`ifdef FETCH_BKPT_EN
         hit = ld && bkpt_en && (ADDR == bkpt_addr);
`endif
         if (RST) nh = 1'b0;
         else if (!exp_halted) nh = halt_req || hit;
         else nh = halt_req || !resume_req;
         drained    = nh && exp_halted && !RST && (drained || xfer || !instr_valid);
         exp_halted = nh;
         prev_rst   = RST;
         prev_stall = instr_valid && !instr_ready;
         prev_flush = RST || redirect_valid;
         prev_pc    = instr_pc;
         prev_instr = instr;
      end
   end

   initial begin
      logic r, rv, h, rs, rdy;
      logic [15:0] ra;
      exp_halted = 1'b0;
      drained    = 1'b0;
      prev_rst   = 1'b1;
      prev_stall = 1'b0;
      prev_flush = 1'b1;
      prev_pc    = 16'h0000;
      prev_instr = '0;
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      tick();
      mon_en = 1'b1;
      tick();
      check("d_rst_valid", {31'd0, instr_valid}, 32'd0);
      // Streaming with instr_ready held high
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("d_stream_pc", {16'd0, instr_pc}, k);
         check("d_stream_valid", {31'd0, instr_valid}, 32'd1);
      end
      // Back-pressure at instr_pc=2
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      check("d_bp_start", {16'd0, instr_pc}, 32'd2);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("d_bp_pc", {16'd0, instr_pc}, 32'd2);
         check("d_bp_instr", {11'd0, instr}, {11'd0, rom_word(16'd2)});
         check("d_bp_addr", {16'd0, ADDR}, 32'd3);
      end
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      tick();
      check("d_bp_release", {16'd0, instr_pc}, 32'd3);
      tick();
      tick();
      check("d_pre_redirect", {16'd0, instr_pc}, 32'd5);
      // Redirect to 0x000C
      drive(1'b0, 1'b1, 1'b1, 16'h000C, 1'b0, 1'b0);
      tick();
      check("d_redir_bubble", {31'd0, instr_valid}, 32'd0);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      tick();
      check("d_redir_valid", {31'd0, instr_valid}, 32'd1);
      check("d_redir_pc", {16'd0, instr_pc}, 32'h000C);
      // Wrap at 0xFFFF
      drive(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      tick();
      check("d_wrap_ffff", {16'd0, instr_pc}, 32'h0000FFFF);
      tick();
      check("d_wrap_0000", {16'd0, instr_pc}, 32'd0);
      check("d_wrap_valid", {31'd0, instr_valid}, 32'd1);
      // Halt while stalled, drain, resume, then simultaneous halt+resume
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      tick();
      check("d_halt_flag", {31'd0, halted}, 32'd1);
      check("d_halt_offer", {31'd0, instr_valid}, 32'd1);
      check("d_halt_pc", {16'd0, instr_pc}, 32'd0);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
         check("d_halt_empty", {31'd0, instr_valid}, 32'd0);
         check("d_halt_addr", {16'd0, ADDR}, 32'd1);
         tick();
      end
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
      tick();
      check("d_resume_flag", {31'd0, halted}, 32'd0);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      tick();
      check("d_resume_pc", {16'd0, instr_pc}, 32'd1);
      check("d_resume_valid", {31'd0, instr_valid}, 32'd1);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
      tick();
      check("d_both_run", {31'd0, halted}, 32'd1);
      tick();
      check("d_both_halted", {31'd0, halted}, 32'd1);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
      tick();
      check("d_resume2", {31'd0, halted}, 32'd0);
`ifdef FETCH_BKPT_EN
      // Breakpoint at address 4
      bkpt_en   = 1'b1;
      bkpt_addr = 16'h0004;
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) tick();
      check("d_bkpt_pc", {16'd0, instr_pc}, 32'd4);
      check("d_bkpt_halted", {31'd0, halted}, 32'd1);
      check("d_bkpt_addr", {16'd0, ADDR}, 32'd5);
      bkpt_en = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
      tick();
`endif
      // Random traffic
      for (int c = 0; c < 2500; c++) begin
         r   = ($urandom_range(0, 299) == 0);
         rv  = ($urandom_range(0, 24) == 0);
         ra  = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                           : 16'($urandom_range(0, 65535));
         h   = ($urandom_range(0, 29) == 0);
         rs  = ($urandom_range(0, 7) == 0);
         rdy = ($urandom_range(0, 3) != 0);
`ifdef FETCH_BKPT_EN
         bkpt_en   = ($urandom_range(0, 3) == 0);
         bkpt_addr = ADDR + 16'($urandom_range(0, 3));
`endif
         drive(r, rdy, rv, ra, h, rs);
         tick();
      end
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) tick();
      check("xfer_count", {31'd0, (xfers > 300)}, 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
